i2s_capture: RTL and testbench

I2S_CAPTURE -- requirements
Module: i2s_capture

---
 rtl/i2s_pkg.sv | 13 +
 rtl/i2s_sync_edge.sv | 38 +++
 rtl/i2s_capture.sv | 190 +++++++++++++++++++
 tb/tb_i2s_capture.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: capture FSM states and overrun counter width.
// Also intended for use by i2s_fifo.
package i2s_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLeft,
    StRight
  } i2s_state_e;

  localparam int unsigned OVR_CNT_W = 16;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with a one-cycle pulse
// on each synchronized 0->1 transition.
module i2s_sync_edge #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  logic [Stages-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = d_i;
    for (int i = 1; i < int'(Stages); i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[Stages-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q[Stages-1];
  assign rise_o = sync_q[Stages-1] & ~prev_q;

endmodule

// File: rtl/i2s_capture.sv
// I2S receiver: captures {left, right} sample pairs from an asynchronous I2S
// bus into the CLK domain and hands them off with a valid/ready interface.
module i2s_capture
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 sck,
  input  logic                 ws,
  input  logic                 sd,
  input  logic                 en,
  output logic [2*WIDTH-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 clr_overrun,
  output logic                 overrun,
  output logic [OVR_CNT_W-1:0] overrun_count
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic sck_s, sck_rise, ws_s, ws_rise, sd_s, sd_rise;

  i2s_sync_edge #(.Stages(SYNC_STAGES)) u_sync_sck (
    .clk_i  (CLK),
    .rst_ni (RST),
    .d_i    (sck),
    .q_o    (sck_s),
    .rise_o (sck_rise)
  );

  i2s_sync_edge #(.Stages(SYNC_STAGES)) u_sync_ws (
    .clk_i  (CLK),
    .rst_ni (RST),
    .d_i    (ws),
    .q_o    (ws_s),
    .rise_o (ws_rise)
  );

  i2s_sync_edge #(.Stages(SYNC_STAGES)) u_sync_sd (
    .clk_i  (CLK),
    .rst_ni (RST),
    .d_i    (sd),
    .q_o    (sd_s),
    .rise_o (sd_rise)
  );

  logic unused_sync;
  assign unused_sync = ^{sck_s, ws_rise, sd_rise};

  i2s_state_e           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]     left_q, left_d, right_q, right_d;
  logic                 ws_prev_q, ws_prev_d;
  logic [2*WIDTH-1:0]   data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;
  logic [OVR_CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;

  logic                 slot_bit, ws_edge, pair_done;
  logic [WIDTH-1:0]     bit_mask;
  logic [2*WIDTH-1:0]   pair;

  // Capture FSM: bits land MSB first at position WIDTH-1-cnt into pre-cleared
  // shift registers, so a short slot is left-justified with zero LSBs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    right_d   = right_q;
    ws_prev_d = ws_prev_q;
    pair_done = 1'b0;
    pair      = {left_q, right_q};
    ws_edge   = ws_s ^ ws_prev_q;
    slot_bit  = cnt_q < CntW'(WIDTH);
    for (int i = 0; i < int'(WIDTH); i++) begin
      bit_mask[i] = slot_bit && sd_s && (cnt_q == CntW'(int'(WIDTH) - 1 - i));
    end

    if (!en) begin
      state_d = StIdle;
      cnt_d   = '0;
    end

    if (sck_rise) begin
      ws_prev_d = ws_s;
      if (en) begin
        unique case (state_q)
          StIdle: begin
            if (ws_prev_q && !ws_s) begin
              state_d = StLeft;
              cnt_d   = '0;
              left_d  = '0;
              right_d = '0;
            end
          end
          StLeft: begin
            // On the ws edge the bit still belongs to the channel being left.
            left_d = left_q | bit_mask;
            if (ws_edge) begin
              state_d = StRight;
              cnt_d   = '0;
            end else if (slot_bit) begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
          StRight: begin
            right_d = right_q | bit_mask;
            if (ws_edge) begin
              pair_done = 1'b1;
              pair      = {left_q, right_d};
              state_d   = StLeft;
              cnt_d     = '0;
              left_d    = '0;
              right_d   = '0;
            end else if (slot_bit) begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
          default: begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  // Output holding register and overrun tracking.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    ovr_cnt_d = ovr_cnt_q;

    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if (pair_done) begin
      if (!valid_q || out_ready) begin
        data_d  = pair;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
        if (ovr_cnt_q != '1) begin
          ovr_cnt_d = ovr_cnt_q + OVR_CNT_W'(1);
        end
      end
    end

    if (clr_overrun) begin
      ovr_d     = 1'b0;
      ovr_cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      left_q    <= '0;
      right_q   <= '0;
      ws_prev_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      ovr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
      right_q   <= right_d;
      ws_prev_q <= ws_prev_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign out_data      = data_q;
  assign out_valid     = valid_q;
  assign overrun       = ovr_q;
  assign overrun_count = ovr_cnt_q;

endmodule

// File: tb/tb_i2s_capture.sv
// Scoreboard bench for i2s_capture: directed I2S frames drive the bus, expected
// pairs are queued, and a monitor compares every accepted output pair.
module tb_i2s_capture;

  localparam int unsigned W       = 16;
  localparam int unsigned SS      = 2;
  localparam int          HalfSck = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sck = 1'b0;
  logic          ws = 1'b1;
  logic          sd = 1'b0;
  logic          en = 1'b0;
  logic          out_ready = 1'b1;
  logic          clr_overrun = 1'b0;
  logic [2*W-1:0] out_data;
  logic          out_valid;
  logic          overrun;
  logic [15:0]   overrun_count;

  int            n_checks = 0;
  int            n_pass = 0;
  int            cyc_n = 0;
  int            rise_cyc = 0;
  logic          pend = 1'b0;
  logic [31:0]   exp_q[$];
  logic          valid_prev = 1'b0;
  logic          hs_prev = 1'b0;

  i2s_capture #(
    .WIDTH       (W),
    .SYNC_STAGES (SS)
  ) dut (
    .CLK           (clk),
    .RST           (rst_n),
    .sck           (sck),
    .ws            (ws),
    .sd            (sd),
    .en            (en),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .clr_overrun   (clr_overrun),
    .overrun       (overrun),
    .overrun_count (overrun_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One sck period: ws/sd change while sck is low, receiver samples on the rise.
  task automatic send_period(input logic wsv, input logic sdv);
    sck = 1'b0;
    ws  = wsv;
    sd  = sdv;
    cyc(HalfSck);
    sck      = 1'b1;
    rise_cyc = cyc_n;
    cyc(HalfSck);
  endtask

  // sd lags ws by one period: each period carries the previous data bit.
  task automatic send_slot(input logic wsv, input logic [31:0] v, input int slot,
                           input int nbits);
    for (int i = 0; i < nbits; i++) begin
      send_period(wsv, pend);
      pend = v[slot-1-i];
    end
  endtask

  task automatic frame(input logic [31:0] l, input logic [31:0] r, input int slot);
    send_slot(1'b0, l, slot, slot);
    send_slot(1'b1, r, slot, slot);
  endtask

  task automatic flush();
    send_period(1'b0, pend);
  endtask

  task automatic resync();
    en = 1'b0;
    send_period(1'b1, 1'b0);
    send_period(1'b1, 1'b0);
    en = 1'b1;
    send_period(1'b1, 1'b0);
    send_period(1'b1, 1'b0);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      cyc(1);
      k++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: latency of each new pair, single-cycle valid after a handshake,
  // and pair contents against the scoreboard queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !valid_prev) check("latency", 32'(cyc_n - rise_cyc), 32'(SS + 1));
      if (hs_prev) check("valid_drop", 32'(out_valid), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pair: got %h, expected none", out_data);
        end else begin
          check("pair", out_data, exp_q.pop_front());
        end
      end
    end
    valid_prev = out_valid;
    hs_prev    = rst_n && out_valid && out_ready;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(3);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_count", 32'(overrun_count), 32'd0);
    rst_n = 1'b1;
    cyc(2);
    en = 1'b1;
    repeat (3) send_period(1'b1, 1'b0);

    exp_q.push_back(32'hA5C31234);
    frame(32'hA5C3, 32'h1234, 16);
    flush();
    wait_drain(64);
    resync();

    exp_q.push_back(32'hABCD1234);
    frame(32'hABCDEF, 32'h123456, 24);
    flush();
    wait_drain(64);
    resync();

    exp_q.push_back(32'hFFF08000);
    frame(32'hFFF, 32'h800, 12);
    flush();
    wait_drain(64);
    resync();

    // Three frames with no acceptance: first pair held, two dropped.
    out_ready = 1'b0;
    exp_q.push_back(32'h11112222);
    frame(32'h1111, 32'h2222, 16);
    frame(32'h3333, 32'h4444, 16);
    frame(32'h5555, 32'h6666, 16);
    flush();
    cyc(8);
    check("held_valid", 32'(out_valid), 32'd1);
    check("held_data", out_data, 32'h11112222);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_count", 32'(overrun_count), 32'd2);
    clr_overrun = 1'b1;
    cyc(1);
    clr_overrun = 1'b0;
    check("clr_flag", 32'(overrun), 32'd0);
    check("clr_count", 32'(overrun_count), 32'd0);
    check("clr_keeps_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    wait_drain(16);
    resync();

    // Reset mid-LEFT with an undelivered pair pending.
    out_ready = 1'b0;
    frame(32'h0F0F, 32'hF0F0, 16);
    flush();
    send_slot(1'b0, 32'hBEEF, 16, 5);
    rst_n = 1'b0;
    cyc(3);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    check("mid_rst_count", 32'(overrun_count), 32'd0);
    out_ready = 1'b1;
    rst_n     = 1'b1;
    send_slot(1'b0, 32'hBEEF, 16, 11);
    send_slot(1'b1, 32'hCAFE, 16, 16);
    exp_q.push_back(32'h9A5E0C3B);
    frame(32'h9A5E, 32'h0C3B, 16);
    flush();
    wait_drain(64);
    resync();

    // Enable dropped mid-RIGHT: the partial pair must never appear.
    send_slot(1'b0, 32'h7777, 16, 16);
    send_slot(1'b1, 32'h8888, 16, 7);
    en = 1'b0;
    cyc(20);
    en = 1'b1;
    send_slot(1'b1, 32'h8888, 16, 9);
    exp_q.push_back(32'h2468ACE0);
    frame(32'h2468, 32'hACE0, 16);
    flush();
    wait_drain(64);
    cyc(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
